// File: rtl/pipe_elastic_buffer.sv
// pipe_elastic_buffer: elastic pipeline register with a DEPTH-entry skid FIFO.
// Upstream and downstream use independent valid/ready handshakes. in_ready and
// out_valid come straight from registers, so no combinational path runs from
// out_ready to in_ready or from in_data to out_data.
// An empty buffer presents BUBBLE on out_data.
// Optional build macro PIPE_BUF_STATS_EN adds the stall_cycles and
// high_water statistics outputs.
module pipe_elastic_buffer #(
  parameter int               WIDTH  = 32,
  parameter int               DEPTH  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PIPE_BUF_STATS_EN
  ,
  output logic [31:0]                stall_cycles,
  output logic [$clog2(DEPTH+1)-1:0] high_water
`endif
);

  localparam int              CW       = $clog2(DEPTH + 1);
  localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_next_s;
  logic [PW-1:0]    rd_ptr_next_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             push_s;
  logic             pop_s;

  // Pointer advance with an explicit wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == LAST_PTR) begin
      return {PW{1'b0}};
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  // Handshake decode and next-state for pointers and occupancy; flush wins.
  always_comb begin
    push_s        = in_valid && in_ready_r && !flush;
    pop_s         = out_valid_r && out_ready && !flush;
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    count_next_s  = count_r;
    if (flush) begin
      wr_ptr_next_s = {PW{1'b0}};
      rd_ptr_next_s = {PW{1'b0}};
      count_next_s  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_next_s = ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_next_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_next_s = ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_next_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + CW'(1);
        2'b01:   count_next_s = count_r - CW'(1);
        default: count_next_s = count_r;
      endcase
    end
  end

  // Control state; ready/valid flags are precomputed from the next occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_next_s;
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      in_ready_r  <= (count_next_s != DEPTH_C);
      out_valid_r <= (count_next_s != {CW{1'b0}});
    end
  end

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign count     = count_r;
  assign out_data  = out_valid_r ? mem_r[rd_ptr_r] : BUBBLE;

`ifdef PIPE_BUF_STATS_EN
  logic [31:0]   stall_cycles_r;
  logic [CW-1:0] high_water_r;

  // Saturating count of cycles where the head is offered but not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_r <= 32'd0;
    end else if (out_valid_r && !out_ready && (stall_cycles_r != 32'hFFFF_FFFF)) begin
      stall_cycles_r <= stall_cycles_r + 32'd1;
    end
  end

  // Peak occupancy since reset; flush intentionally leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_water_r <= {CW{1'b0}};
    end else if (count_next_s > high_water_r) begin
      high_water_r <= count_next_s;
    end
  end

  assign stall_cycles = stall_cycles_r;
  assign high_water   = high_water_r;
`endif

endmodule

// File: tb/tb_pipe_elastic_buffer.sv
// Directed bench for pipe_elastic_buffer: three instances (DEPTH 2, 3, 4)
// share one clock and reset. Each scenario drives one instance while the
// others stay idle. Expected values are hand-computed constants.
module tb_pipe_elastic_buffer;

  localparam logic [7:0] BUB = 8'hEE;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  // DEPTH=2 instance
  logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_count;
  // DEPTH=3 instance
  logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_count;
  // DEPTH=4 instance
  logic       c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [7:0] c_in_data, c_out_data;
  logic [2:0] c_count;
`ifdef PIPE_BUF_STATS_EN
  logic [31:0] a_stall, b_stall, c_stall;
  logic [1:0]  a_hw, b_hw;
  logic [2:0]  c_hw;
`endif

  pipe_elastic_buffer #(.WIDTH(8), .DEPTH(2), .BUBBLE(BUB)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count)
`ifdef PIPE_BUF_STATS_EN
    , .stall_cycles(a_stall), .high_water(a_hw)
`endif
  );

  pipe_elastic_buffer #(.WIDTH(8), .DEPTH(3), .BUBBLE(BUB)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count)
`ifdef PIPE_BUF_STATS_EN
    , .stall_cycles(b_stall), .high_water(b_hw)
`endif
  );

  pipe_elastic_buffer #(.WIDTH(8), .DEPTH(4), .BUBBLE(BUB)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .count(c_count)
`ifdef PIPE_BUF_STATS_EN
    , .stall_cycles(c_stall), .high_water(c_hw)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h01; a_out_ready = 1'b1;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b0;
    c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = 8'h00; c_out_ready = 1'b0;

    // Reset held for 3 cycles with in_valid high
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst in_ready",  32'(a_in_ready),  32'h1);
      chk("rst out_valid", 32'(a_out_valid), 32'h0);
      chk("rst out_data",  32'(a_out_data),  32'(BUB));
      chk("rst count",     32'(a_count),     32'h0);
    end
    rst_n = 1'b1;

    // Streaming 0x1..0x8 with 1-cycle latency and in_ready held high
    for (int i = 1; i <= 8; i++) begin
      a_in_data  = 8'(i);
      a_in_valid = 1'b1;
      step();
      chk("stream out_data",  32'(a_out_data),  32'(i));
      chk("stream out_valid", 32'(a_out_valid), 32'h1);
      chk("stream in_ready",  32'(a_in_ready),  32'h1);
      chk("stream count",     32'(a_count),     32'h1);
    end
    a_in_valid = 1'b0;
    step();
    chk("stream drain valid", 32'(a_out_valid), 32'h0);
    chk("stream drain data",  32'(a_out_data),  32'(BUB));

    // Backpressure on DEPTH=3: fill A,B,C with out_ready low
    b_in_valid = 1'b1; b_in_data = 8'h0A; step();
    b_in_data = 8'h0B; step();
    b_in_data = 8'h0C; step();
    chk("bp full count",    32'(b_count),    32'h3);
    chk("bp full in_ready", 32'(b_in_ready), 32'h0);
    chk("bp head",          32'(b_out_data), 32'h0A);
    b_in_data = 8'h0D; step();
    chk("bp refused count", 32'(b_count),    32'h3);
    b_out_ready = 1'b1; step();
    b_out_ready = 1'b0;
    chk("bp pop count",     32'(b_count),    32'h2);
    chk("bp pop in_ready",  32'(b_in_ready), 32'h1);
    chk("bp pop head",      32'(b_out_data), 32'h0B);
    step();
    b_in_valid = 1'b0;
    chk("bp D count",       32'(b_count),    32'h3);
    chk("bp D in_ready",    32'(b_in_ready), 32'h0);
    chk("bp D head",        32'(b_out_data), 32'h0B);
    b_out_ready = 1'b1;
    step(); chk("bp order C", 32'(b_out_data), 32'h0C);
    step(); chk("bp order D", 32'(b_out_data), 32'h0D);
    step();
    chk("bp empty valid", 32'(b_out_valid), 32'h0);
    chk("bp empty data",  32'(b_out_data),  32'(BUB));
    chk("bp empty count", 32'(b_count),     32'h0);

    // Wrap-around on DEPTH=3: 10 simultaneous push/pop pairs at count=1
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 8'h10; step();
    b_out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      b_in_data = 8'(8'h10 + i);
      step();
      chk("wrap data",  32'(b_out_data), 32'(8'h10 + i));
      chk("wrap count", 32'(b_count),    32'h1);
    end
    b_in_valid = 1'b0;
    step();
    chk("wrap drain", 32'(b_count), 32'h0);

    // Flush on DEPTH=4 holding 2 entries, with a push in the flush cycle
    c_in_valid = 1'b1; c_in_data = 8'h31; step();
    c_in_data = 8'h32; step();
    chk("fl pre count", 32'(c_count), 32'h2);
    c_flush = 1'b1; c_in_data = 8'h55; step();
    c_flush = 1'b0; c_in_valid = 1'b0;
    chk("fl count",     32'(c_count),     32'h0);
    chk("fl out_valid", 32'(c_out_valid), 32'h0);
    chk("fl out_data",  32'(c_out_data),  32'(BUB));
    chk("fl in_ready",  32'(c_in_ready),  32'h1);
    c_out_ready = 1'b1; step();
    c_out_ready = 1'b0;
    chk("fl no 0x55 data",  32'(c_out_data), 32'(BUB));
    chk("fl empty pop cnt", 32'(c_count),    32'h0);
    c_in_valid = 1'b1; c_in_data = 8'h66; step();
    c_in_valid = 1'b0;
    chk("fl repush data",  32'(c_out_data), 32'h66);
    chk("fl repush count", 32'(c_count),    32'h1);

`ifdef PIPE_BUF_STATS_EN
    // Stall counting: one entry held for 5 cycles with out_ready low
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'h77; step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("st stall_cycles", a_stall,    32'd5);
    chk("st high_water",   32'(a_hw),  32'd1);
    // Fill DEPTH=4 to 3 and flush: high_water stays at 3
    c_in_valid = 1'b1; c_in_data = 8'h67; step();
    c_in_data = 8'h68; step();
    c_in_valid = 1'b0;
    chk("st fill count", 32'(c_count), 32'd3);
    c_flush = 1'b1; step();
    c_flush = 1'b0;
    chk("st flush count", 32'(c_count), 32'd0);
    chk("st hw kept",     32'(c_hw),    32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
